// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the multi-commit register file.
//
// Contents:
//   XLEN, NUM_REGS, REG_W, ROB_WIDTH, NUM_READ, COMMIT_WIDTH  sizing constants
//   reg_id_t, rob_tag_t, word_t                              scalar typedefs
//   commit_slot_t                                            one commit lane {valid, rd, tag, value}
//   slot_hits()                                              true when a commit lane retires the
//                                                            pending producer of a busy register
package rf_pkg;

  localparam int XLEN         = 32;
  localparam int NUM_REGS     = 32;
  localparam int REG_W        = $clog2(NUM_REGS);
  localparam int ROB_WIDTH    = 4;
  localparam int NUM_READ     = 2;
  localparam int COMMIT_WIDTH = 2;

  typedef logic [REG_W-1:0]     reg_id_t;
  typedef logic [ROB_WIDTH-1:0] rob_tag_t;
  typedef logic [XLEN-1:0]      word_t;

  typedef struct packed {
    logic     valid;
    reg_id_t  rd;
    rob_tag_t tag;
    word_t    value;
  } commit_slot_t;

  // A commit lane resolves register 'id' only when it targets that register,
  // the register is still waiting, and the lane carries the producer's tag.
  function automatic logic slot_hits(commit_slot_t s, reg_id_t id,
                                     logic busy, rob_tag_t tag);
    return s.valid && (s.rd == id) && (id != '0) && busy && (tag == s.tag);
  endfunction

endpackage

// File: rtl/register_file_mc_if.sv
// Issue / operand-read / commit bus of the register file.
//
// Signals:
//   issue_valid_in, issue_rd_in, issue_tag_in   rd tag claim for a newly issued instruction
//   rs_id_in                                    flattened source ids, port p = [p*REG_W +: REG_W]
//   rs_value_out, rs_tag_out, rs_busy_out       combinational operand read results
//   commit_valid_in, commit_rd_in,
//   commit_tag_in, commit_value_in              COMMIT_WIDTH in-order retire lanes, lane 0 oldest
//
// Handshake: there is no ready back-pressure on this bus. A strobe
// (issue_valid_in or commit_valid_in[k]) is taken at the rising clock edge
// whenever the register file's rdy_in is high; with rdy_in low the strobe is
// ignored and the producer must hold or replay it. Read results are valid in
// the same cycle the ids are presented.
//
// Modports: master = pipeline driving the bus, slave = register file.
interface register_file_mc_if;
  import rf_pkg::*;

  logic                              issue_valid_in;
  reg_id_t                           issue_rd_in;
  rob_tag_t                          issue_tag_in;

  logic [NUM_READ*REG_W-1:0]         rs_id_in;
  logic [NUM_READ*XLEN-1:0]          rs_value_out;
  logic [NUM_READ*ROB_WIDTH-1:0]     rs_tag_out;
  logic [NUM_READ-1:0]               rs_busy_out;

  logic [COMMIT_WIDTH-1:0]           commit_valid_in;
  logic [COMMIT_WIDTH*REG_W-1:0]     commit_rd_in;
  logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commit_tag_in;
  logic [COMMIT_WIDTH*XLEN-1:0]      commit_value_in;

  modport master (
    output issue_valid_in, issue_rd_in, issue_tag_in, rs_id_in,
    output commit_valid_in, commit_rd_in, commit_tag_in, commit_value_in,
    input  rs_value_out, rs_tag_out, rs_busy_out
  );

  modport slave (
    input  issue_valid_in, issue_rd_in, issue_tag_in, rs_id_in,
    input  commit_valid_in, commit_rd_in, commit_tag_in, commit_value_in,
    output rs_value_out, rs_tag_out, rs_busy_out
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational operand read port of the register file.
//
// Ports:
//   rs_id      in   source register id
//   reg_value  in   architectural values of all registers
//   reg_tag    in   rename tags of all registers
//   reg_busy   in   busy bits of all registers
//   slots      in   this cycle's commit lanes (only with RF_COMMIT_BYPASS_EN)
//   value      out  operand value (x0 forced to 0)
//   tag        out  producing ROB tag, meaningful when busy
//   busy       out  1 = value still pending in the ROB
//
// Build option: RF_COMMIT_BYPASS_EN forwards a same-cycle commit that
// resolves the busy register straight to the port.
module rf_read_port
  import rf_pkg::*;
(
  input  reg_id_t                rs_id,
  input  word_t                  reg_value [NUM_REGS],
  input  rob_tag_t               reg_tag   [NUM_REGS],
  input  logic [NUM_REGS-1:0]    reg_busy,
`ifdef RF_COMMIT_BYPASS_EN
  input  commit_slot_t           slots     [COMMIT_WIDTH],
`endif
  output word_t                  value,
  output rob_tag_t               tag,
  output logic                   busy
);

  always_comb begin
    value = reg_value[rs_id];
    tag   = reg_tag[rs_id];
    busy  = reg_busy[rs_id];
    if (rs_id == '0) begin
      value = '0;
      tag   = '0;
      busy  = 1'b0;
    end
`ifdef RF_COMMIT_BYPASS_EN
    // Ascending scan: a later (younger) matching lane overrides an older one.
    // The match uses the registered busy/tag, never the bypassed result.
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (slot_hits(slots[k], rs_id, reg_busy[rs_id], reg_tag[rs_id])) begin
        value = slots[k].value;
        busy  = 1'b0;
      end
    end
`endif
  end

endmodule

// File: rtl/register_file_mc.sv
// Architectural register file with busy/tag rename tracking and
// COMMIT_WIDTH in-order commits per cycle.
//
// Ports:
//   clk_in        in   system clock
//   rst_n_in      in   asynchronous active-low reset (clears values, tags, busy)
//   rdy_in        in   0 freezes every state update, including clear
//   clear_in      in   mispredict flush: drop rename state, keep values
//   bus           slave modport of register_file_mc_if (issue, reads, commits)
//   value_x1_out  out  architectural x1 for JALR target prediction
//
// Build option: RF_COMMIT_BYPASS_EN -- reads (and value_x1_out) see a
// same-cycle commit that resolves the busy register. Without it a commit in
// cycle N is visible from cycle N+1.
module register_file_mc
  import rf_pkg::*;
(
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  register_file_mc_if.slave        bus,
  output word_t                    value_x1_out
);

  word_t               value_q [NUM_REGS];
  word_t               value_d [NUM_REGS];
  rob_tag_t            tag_q   [NUM_REGS];
  rob_tag_t            tag_d   [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  commit_slot_t        slots   [COMMIT_WIDTH];

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slots[k].valid = bus.commit_valid_in[k];
      slots[k].rd    = bus.commit_rd_in[k*REG_W +: REG_W];
      slots[k].tag   = bus.commit_tag_in[k*ROB_WIDTH +: ROB_WIDTH];
      slots[k].value = bus.commit_value_in[k*XLEN +: XLEN];
    end
  end

  // Next-state: commits first (ascending so the younger lane wins a shared
  // rd), then issue on top so a same-cycle claim keeps the register busy,
  // then clear which wipes rename state but leaves committed values.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (slots[k].valid && (slots[k].rd != '0)) begin
        value_d[slots[k].rd] = slots[k].value;
        busy_d[slots[k].rd]  = (busy_q[slots[k].rd] && (tag_q[slots[k].rd] == slots[k].tag))
                               ? 1'b0 : busy_q[slots[k].rd];
      end
    end
    if (clear_in) begin
      busy_d = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_d[r] = '0;
      end
    end else if (bus.issue_valid_in && (bus.issue_rd_in != '0)) begin
      tag_d[bus.issue_rd_in]  = bus.issue_tag_in;
      busy_d[bus.issue_rd_in] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_read
    rf_read_port u_read_port (
      .rs_id     (bus.rs_id_in[p*REG_W +: REG_W]),
      .reg_value (value_q),
      .reg_tag   (tag_q),
      .reg_busy  (busy_q),
`ifdef RF_COMMIT_BYPASS_EN
      .slots     (slots),
`endif
      .value     (bus.rs_value_out[p*XLEN +: XLEN]),
      .tag       (bus.rs_tag_out[p*ROB_WIDTH +: ROB_WIDTH]),
      .busy      (bus.rs_busy_out[p])
    );
  end

  always_comb begin
    value_x1_out = value_q[1];
`ifdef RF_COMMIT_BYPASS_EN
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (slot_hits(slots[k], reg_id_t'(1), busy_q[1], tag_q[1])) begin
        value_x1_out = slots[k].value;
      end
    end
`endif
  end

endmodule

// File: tb/tb_register_file_mc.sv
// Bench for register_file_mc: directed vector table plus randomized traffic
// checked against a register-level reference model.
module tb_register_file_mc;

`ifdef RF_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic [31:0] value_x1_out;

  register_file_mc_if bus ();

  register_file_mc dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear_in     (clear_in),
    .bus          (bus),
    .value_x1_out (value_x1_out)
  );

  // ---------------- clock ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rdy, input logic clr, input logic iv,
                       input logic [4:0] ird, input logic [3:0] itag,
                       input logic c0v, input logic [4:0] c0rd, input logic [3:0] c0tag,
                       input logic [31:0] c0val,
                       input logic c1v, input logic [4:0] c1rd, input logic [3:0] c1tag,
                       input logic [31:0] c1val,
                       input logic [4:0] rs0, input logic [4:0] rs1);
    rdy_in              = rdy;
    clear_in            = clr;
    bus.issue_valid_in  = iv;
    bus.issue_rd_in     = ird;
    bus.issue_tag_in    = itag;
    bus.commit_valid_in = {c1v, c0v};
    bus.commit_rd_in    = {c1rd, c0rd};
    bus.commit_tag_in   = {c1tag, c0tag};
    bus.commit_value_in = {c1val, c0val};
    bus.rs_id_in        = {rs1, rs0};
  endtask

  task automatic check_port(input string name, input int p,
                            input logic [31:0] ev, input logic eb, input logic [3:0] et);
    check({name, $sformatf(" p%0d value", p)}, bus.rs_value_out[p*32 +: 32], ev);
    check({name, $sformatf(" p%0d busy", p)}, {31'd0, bus.rs_busy_out[p]}, {31'd0, eb});
    check({name, $sformatf(" p%0d tag", p)}, {28'd0, bus.rs_tag_out[p*4 +: 4]}, {28'd0, et});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rdy, clr, iv;
    logic [4:0]  ird;
    logic [3:0]  itag;
    logic        c0v;
    logic [4:0]  c0rd;
    logic [3:0]  c0tag;
    logic [31:0] c0val;
    logic        c1v;
    logic [4:0]  c1rd;
    logic [3:0]  c1tag;
    logic [31:0] c1val;
    logic [4:0]  rs0, rs1;
    logic [31:0] e0v;
    logic        e0b;
    logic [3:0]  e0t;
    logic [31:0] e1v;
    logic        e1b;
    logic [3:0]  e1t;
    logic [31:0] ex1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rdy, logic clr, logic iv, logic [4:0] ird, logic [3:0] itag,
                              logic c0v, logic [4:0] c0rd, logic [3:0] c0tag, logic [31:0] c0val,
                              logic c1v, logic [4:0] c1rd, logic [3:0] c1tag, logic [31:0] c1val,
                              logic [4:0] rs0, logic [4:0] rs1,
                              logic [31:0] e0v, logic e0b, logic [3:0] e0t,
                              logic [31:0] e1v, logic e1b, logic [3:0] e1t, logic [31:0] ex1);
    vec_t v;
    v.rdy = rdy; v.clr = clr; v.iv = iv; v.ird = ird; v.itag = itag;
    v.c0v = c0v; v.c0rd = c0rd; v.c0tag = c0tag; v.c0val = c0val;
    v.c1v = c1v; v.c1rd = c1rd; v.c1tag = c1tag; v.c1val = c1val;
    v.rs0 = rs0; v.rs1 = rs1;
    v.e0v = e0v; v.e0b = e0b; v.e0t = e0t;
    v.e1v = e1v; v.e1b = e1b; v.e1t = e1t; v.ex1 = ex1;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [3:0]  m_tag  [32];
  logic        r_cv   [2];
  logic [4:0]  r_crd  [2];
  logic [3:0]  r_ctag [2];
  logic [31:0] r_cval [2];

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
    end
  endtask

  // Reads see the state before this cycle's update; with bypass enabled the
  // youngest lane that retires the pending producer supplies the value.
  task automatic model_read(input logic [4:0] rs, output logic [31:0] v,
                            output logic b, output logic [3:0] t);
    v = 0; b = 0; t = 0;
    if (rs != 0) begin
      v = m_val[rs]; b = m_busy[rs]; t = m_tag[rs];
      if (BYP) begin
        for (int k = 1; k >= 0; k--) begin
          if (r_cv[k] && r_crd[k] == rs && m_busy[rs] && m_tag[rs] == r_ctag[k]) begin
            v = r_cval[k]; b = 0;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_update(input logic clr, input logic iv, input logic [4:0] ird,
                              input logic [3:0] itag);
    for (int r = 1; r < 32; r++) begin
      // The youngest lane targeting r decides both the value and the release.
      for (int k = 1; k >= 0; k--) begin
        if (r_cv[k] && r_crd[k] == r) begin
          if (m_busy[r] && m_tag[r] == r_ctag[k]) m_busy[r] = 0;
          m_val[r] = r_cval[k];
          break;
        end
      end
    end
    if (clr) begin
      for (int r = 0; r < 32; r++) begin
        m_busy[r] = 0; m_tag[r] = 0;
      end
    end else if (iv && ird != 0) begin
      m_busy[ird] = 1; m_tag[ird] = itag;
    end
  endtask

  logic        q_rdy, q_clr, q_iv;
  logic [4:0]  q_ird, q_rs0, q_rs1;
  logic [3:0]  q_itag;
  logic [31:0] x_v;
  logic        x_b;
  logic [3:0]  x_t;

  initial begin
    // ---------------- reset ----------------
    rst_n_in = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd5);
    #12;
    check_port("reset", 0, 0, 0, 0);
    check_port("reset", 1, 0, 0, 0);
    check("reset x1", value_x1_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 5,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,0,0,32'hDEAD, 0,0,0,0, 0,5, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,3,4, 0,0,0,0, 0,0,0,0, 3,3, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,3,4,32'h1234, 0,0,0,0, 3,0,
                      BYP ? 32'h1234 : 32'h0, !BYP, 4, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 3,0, 32'h1234,0,4, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,7,2, 0,0,0,0, 0,0,0,0, 7,3, 0,0,0, 32'h1234,0,4, 0));
    vecs.push_back(mk(1,0,1,7,5, 0,0,0,0, 0,0,0,0, 7,0, 0,1,2, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,7,2,32'hAA, 0,0,0,0, 7,0, 0,1,5, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 7,0, 32'hAA,1,5, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,9,1, 0,0,0,0, 0,0,0,0, 9,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,9,2, 0,0,0,0, 0,0,0,0, 9,0, 0,1,1, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,9,1,32'h11, 1,9,2,32'h22, 9,0,
                      BYP ? 32'h22 : 32'h0, !BYP, 2, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 9,0, 32'h22,0,2, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,4,3, 0,0,0,0, 0,0,0,0, 4,6, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,1,1,6,7, 1,4,3,32'h55, 0,0,0,0, 4,6,
                      BYP ? 32'h55 : 32'h0, !BYP, 3, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 4,6, 32'h55,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 3,7, 32'h1234,0,0, 32'hAA,0,0, 0));
    vecs.push_back(mk(0,0,1,8,6, 0,0,0,0, 0,0,0,0, 8,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 8,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,2,6, 0,0,0,0, 0,0,0,0, 2,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(0,1,0,0,0, 0,0,0,0, 0,0,0,0, 2,0, 0,1,6, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,2,6,32'h99, 0,0,0,0, 2,0,
                      BYP ? 32'h99 : 32'h0, !BYP, 6, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 2,0, 32'h99,0,6, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,10,1, 0,0,0,0, 0,0,0,0, 10,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,1,10,3, 1,10,1,32'h77, 0,0,0,0, 10,0,
                      BYP ? 32'h77 : 32'h0, !BYP, 1, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 10,0, 32'h77,1,3, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 1,1,0,32'hABC, 0,0,0,0, 1,0, 0,0,0, 0,0,0, 0));
    vecs.push_back(mk(1,0,0,0,0, 0,0,0,0, 0,0,0,0, 1,0, 32'hABC,0,0, 0,0,0, 32'hABC));

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].clr, vecs[i].iv, vecs[i].ird, vecs[i].itag,
            vecs[i].c0v, vecs[i].c0rd, vecs[i].c0tag, vecs[i].c0val,
            vecs[i].c1v, vecs[i].c1rd, vecs[i].c1tag, vecs[i].c1val,
            vecs[i].rs0, vecs[i].rs1);
      @(negedge clk_in);
      check_port($sformatf("row%0d", i), 0, vecs[i].e0v, vecs[i].e0b, vecs[i].e0t);
      check_port($sformatf("row%0d", i), 1, vecs[i].e1v, vecs[i].e1b, vecs[i].e1t);
      check($sformatf("row%0d x1", i), value_x1_out, vecs[i].ex1);
      @(posedge clk_in);
      #1;
    end

    // ---------------- reset again, then random traffic ----------------
    @(negedge clk_in);
    rst_n_in = 1'b0;
    #1;
    check_port("rereset", 0, 0, 0, 0);
    check("rereset x1", value_x1_out, 0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;

    for (int n = 0; n < 600; n++) begin
      q_rdy  = ($urandom_range(0, 9) != 0);
      q_clr  = ($urandom_range(0, 24) == 0);
      q_iv   = ($urandom_range(0, 1) == 1);
      q_ird  = 5'($urandom_range(0, 7));
      q_itag = 4'($urandom_range(0, 15));
      for (int k = 0; k < 2; k++) begin
        r_cv[k]   = ($urandom_range(0, 2) != 0);
        r_crd[k]  = 5'($urandom_range(0, 7));
        r_ctag[k] = ($urandom_range(0, 1) == 1) ? m_tag[r_crd[k]] : 4'($urandom_range(0, 15));
        r_cval[k] = $urandom;
      end
      q_rs0 = 5'($urandom_range(0, 7));
      q_rs1 = 5'($urandom_range(0, 7));
      drive(q_rdy, q_clr, q_iv, q_ird, q_itag,
            r_cv[0], r_crd[0], r_ctag[0], r_cval[0],
            r_cv[1], r_crd[1], r_ctag[1], r_cval[1], q_rs0, q_rs1);
      @(negedge clk_in);
      model_read(q_rs0, x_v, x_b, x_t);
      check_port($sformatf("rnd%0d", n), 0, x_v, x_b, x_t);
      model_read(q_rs1, x_v, x_b, x_t);
      check_port($sformatf("rnd%0d", n), 1, x_v, x_b, x_t);
      model_read(5'd1, x_v, x_b, x_t);
      check($sformatf("rnd%0d x1", n), value_x1_out, x_v);
      if (q_rdy) model_update(q_clr, q_iv, q_ird, q_itag);
      @(posedge clk_in);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
